// File: rtl/eth_tx_arb_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: FSM encoding and counter sizing.
// No logic; imported by the arbiter top.
// Beat counter is never narrower than 11 bits, so a full 2047-beat frame can be counted.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int TRUNC_W = 16;

    function automatic int beat_width(input int max_frame);
        int w;
        w = $clog2(max_frame + 1);
        return (w < 11) ? 11 : w;
    endfunction

endpackage

// File: rtl/eth_tx_arb_arbiter_rr.sv
// Round-robin one-hot picker: the search starts at last+1 and wraps.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module arbiter_rr #(
    parameter int PORTS = 2,
    parameter int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] last,
    output logic [PORTS-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(last) + k) % PORTS;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx[PTR_W-1:0];
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter onto the MAC TX stream, with idle gap and runaway-frame truncation.
// Latency: grant one cycle after a request is seen in IDLE; data path is a zero-latency mux.
// Backpressure: granted port's tready follows m_axis_tready; DRAIN sinks input unconditionally.
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0,
    parameter int MAX_FRAME  = 2047
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic [PORTS-1:0]            grant,
    output logic                        busy,
    output logic [TRUNC_W-1:0]          trunc_count
);

    localparam int PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BEAT_W = beat_width(MAX_FRAME);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_FRAME - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);

    arb_state_t             state;
    logic [PTR_W-1:0]       gidx;
    logic [PTR_W-1:0]       last_q;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [TRUNC_W-1:0]     trunc_cnt_q;

    logic [PORTS-1:0]       arb_gnt;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_vld;

    logic [DATA_WIDTH-1:0]  sel_dat;
    logic                   sel_vld;
    logic                   sel_last;
    logic                   sel_user;
    logic                   in_pass;
    logic                   at_max;
    logic                   pass_hs;
    logic                   drain_hs;
    logic                   frame_end;
    logic                   trunc_now;

    arbiter_rr #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (s_axis_tvalid),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign sel_dat  = s_axis_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_vld  = s_axis_tvalid[gidx];
    assign sel_last = s_axis_tlast[gidx];
    assign sel_user = s_axis_tuser[gidx];

    assign in_pass   = (state == ST_PASS);
    assign at_max    = (beat_cnt == LAST_BEAT);
    assign pass_hs   = in_pass && sel_vld && m_axis_tready;
    assign drain_hs  = (state == ST_DRAIN) && sel_vld;
    assign frame_end = (pass_hs || drain_hs) && sel_last;
    // A tlast landing on the final allowed beat is a normal end, not a truncation.
    assign trunc_now = pass_hs && at_max && !sel_last;

    always_comb begin
        m_axis_tvalid = in_pass && sel_vld;
        m_axis_tdata  = in_pass ? sel_dat : '0;
        m_axis_tlast  = in_pass && (sel_last || at_max);
        m_axis_tuser  = in_pass && (sel_user || (at_max && !sel_last));
        s_axis_tready = '0;
        if (in_pass) begin
            s_axis_tready = grant & {PORTS{m_axis_tready}};
        end else if (state == ST_DRAIN) begin
            s_axis_tready = grant;
        end
    end

    assign busy        = (state != ST_IDLE);
    assign trunc_count = trunc_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            gidx        <= '0;
            last_q      <= PTR_W'(PORTS - 1);
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            trunc_cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant    <= arb_gnt;
                        gidx     <= arb_idx;
                        last_q   <= arb_idx;
                        beat_cnt <= '0;
                        state    <= ST_PASS;
                    end
                end
                ST_PASS, ST_DRAIN: begin
                    if (pass_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (frame_end) begin
                        grant <= '0;
                        if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (trunc_now) begin
                        state <= ST_DRAIN;
                        if (trunc_cnt_q != '1) begin
                            trunc_cnt_q <= trunc_cnt_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // Exit on the last gap cycle so IDLE is reached exactly GAP_CYCLES after tlast.
                    if (gap_cnt > GAP_W'(1)) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: per-port sources fed from queues, output checked against a scoreboard.
module tb_eth_tx_arb;

    localparam int PORTS = 2;
    localparam int DW    = 8;
    localparam int GAP   = 4;
    localparam int MAXF  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tready;
    logic [PORTS-1:0]      s_tlast;
    logic [PORTS-1:0]      s_tuser;
    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic                  m_tuser;
    logic [PORTS-1:0]      grant;
    logic                  busy;
    logic [15:0]           trunc_count;

    always #5 clk = ~clk;

    eth_tx_arb #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP),
        .MAX_FRAME  (MAXF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .grant         (grant),
        .busy          (busy),
        .trunc_count   (trunc_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t src_q [PORTS][$];
    beat_t exp_q [PORTS][$];
    int    order_q[$];
    int    start_cyc[$];
    int    end_cyc[$];

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    tready_toggle = 1'b0;
    bit    bp_chk = 1'b0;
    int    frame_beats = 0;
    bit    in_frame = 1'b0;
    int    cur_owner = 0;
    logic [PORTS-1:0] drv_hs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output: beats up to MAXF, with the last allowed beat forced to tlast/tuser on overrun.
    task automatic send_frame(input int p, input int n, input int base, input bit u_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 8'(base + i);
            b.l = (i == n - 1);
            b.u = u_last && (i == n - 1);
            src_q[p].push_back(b);
            if (i < MAXF) begin
                b.l = (i == n - 1) || (i == MAXF - 1);
                b.u = (u_last && (i == n - 1)) || ((i == MAXF - 1) && (n > MAXF));
                exp_q[p].push_back(b);
            end
        end
    endtask

    task automatic clr_log();
        order_q.delete();
        start_cyc.delete();
        end_cyc.delete();
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #1;
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
                   (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   !busy && (s_tvalid == '0);
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Source driver: every requester obeys AXI-stream, advancing only after a handshake.
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        drv_hs   = '0;
        forever begin
            @(negedge clk);
            drv_hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                if (drv_hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = src_q[p][0].d;
                    s_tlast[p]           = src_q[p][0].l;
                    s_tuser[p]           = src_q[p][0].u;
                end else begin
                    s_tvalid[p]          = 1'b0;
                    s_tdata[p*DW +: DW]  = '0;
                    s_tlast[p]           = 1'b0;
                    s_tuser[p]           = 1'b0;
                end
            end
            m_tready = tready_toggle ? ~m_tready : 1'b1;
        end
    end

    // Output monitor and scoreboard.
    initial begin
        int    port;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_tvalid) chk("valid_has_grant", 32'(grant != '0), 32'd1);
                if (bp_chk && grant == 2'b10) begin
                    chk("bp_rdy1_tracks", 32'(s_tready[1]), 32'(m_tready));
                    chk("bp_rdy0_low", 32'(s_tready[0]), 32'd0);
                end
                if (m_tvalid && m_tready) begin
                    port = grant[1] ? 1 : 0;
                    if (in_frame) chk("no_interleave", 32'(port), 32'(cur_owner));
                    else start_cyc.push_back(cyc);
                    in_frame  = 1'b1;
                    cur_owner = port;
                    chk("beat_expected", 32'(exp_q[port].size() != 0), 32'd1);
                    if (exp_q[port].size() != 0) begin
                        e = exp_q[port].pop_front();
                        chk("beat_data", 32'(m_tdata), 32'(e.d));
                        chk("beat_last", 32'(m_tlast), 32'(e.l));
                        chk("beat_user", 32'(m_tuser), 32'(e.u));
                    end
                    frame_beats++;
                    if (m_tlast) begin
                        end_cyc.push_back(cyc);
                        order_q.push_back(port);
                        in_frame    = 1'b0;
                        frame_beats = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trunc", 32'(trunc_count), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Round robin, both ports always offering 3-beat frames.
        @(negedge clk);
        #1;
        clr_log();
        for (int f = 0; f < 4; f++) begin
            send_frame(0, 3, 8'h10 + f * 16, 1'b0);
            send_frame(1, 3, 8'h80 + f * 16, (f == 2));
        end
        wait_done(600, "rr_done");
        chk("rr_frames", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < order_q.size(); i++) chk("rr_order", 32'(order_q[i]), 32'(i % 2));
        for (int i = 1; i < start_cyc.size(); i++)
            chk("rr_turnaround", 32'(start_cyc[i] - end_cyc[i-1]), 32'd6);

        // Backpressure on port 1 with m_tready toggling.
        clr_log();
        tready_toggle = 1'b1;
        bp_chk        = 1'b1;
        send_frame(1, 10, 8'hA0, 1'b0);
        wait_done(300, "bp_done");
        tready_toggle = 1'b0;
        bp_chk        = 1'b0;
        chk("bp_frames", 32'(order_q.size()), 32'd1);

        // Inter-frame gap, back-to-back frames on port 0.
        @(negedge clk);
        #1;
        clr_log();
        send_frame(0, 5, 8'h30, 1'b0);
        send_frame(0, 5, 8'h38, 1'b0);
        wait_done(300, "gap_done");
        chk("gap_frames", 32'(order_q.size()), 32'd2);
        if (start_cyc.size() == 2 && end_cyc.size() == 2)
            chk("gap_first_beat", 32'(start_cyc[1] - end_cyc[0]), 32'd6);

        // Truncation of a 20-beat frame, then an exact-length frame.
        clr_log();
        send_frame(0, 20, 8'h40, 1'b0);
        wait_done(300, "trunc_done");
        chk("trunc_count_1", 32'(trunc_count), 32'd1);
        chk("trunc_frames", 32'(order_q.size()), 32'd1);
        send_frame(0, 16, 8'h60, 1'b0);
        wait_done(300, "exact_done");
        chk("exact_no_trunc", 32'(trunc_count), 32'd1);

        // Reset in the middle of a frame.
        clr_log();
        send_frame(0, 10, 8'hC0, 1'b0);
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            @(negedge clk);
            #1;
            reached = (frame_beats == 4);
        end
        chk("mid_frame_reached", 32'(reached), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        s_tvalid = '0;
        for (int p = 0; p < PORTS; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        in_frame    = 1'b0;
        frame_beats = 0;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_trunc", 32'(trunc_count), 32'd0);
        #1;
        clr_log();
        send_frame(0, 3, 8'hD0, 1'b0);
        send_frame(1, 3, 8'hE0, 1'b0);
        wait_done(300, "post_rst_done");
        chk("post_rst_frames", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            chk("post_rst_first", 32'(order_q[0]), 32'd0);
            chk("post_rst_second", 32'(order_q[1]), 32'd1);
        end

        // Saturation from a preloaded near-full counter.
        @(negedge clk);
        force dut.trunc_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.trunc_cnt_q;
        #1;
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 17, 8'h70 + f * 32, 1'b0);
            wait_done(300, "sat_done");
            chk("sat_count", 32'(trunc_count), 32'hFFFF);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
